// File: rtl/hyperbus_mux_pkg.sv
// Shared types and constants for the HyperBus channel multiplexer.
package hyperbus_mux_pkg;

    // Switch handshake FSM states
    typedef enum logic [1:0] {
        ACTIVE = 2'd0,
        DRAIN  = 2'd1,
        GUARD  = 2'd2,
        SWITCH = 2'd3
    } hyper_mux_state_e;

    // Default parked value; sliced to the data width at the use site
    localparam logic [63:0] HYPER_MUX_IDLE_DEFAULT = '0;

    // Width needed to hold an index in [0, n-1]; never less than one bit
    function automatic int hyper_mux_sel_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/hyperbus_chan_mux_sel.sv
// Purely combinational NB_CH:1 array multiplexer.
// An out-of-range select yields all zeros.
module hyperbus_chan_mux_sel #(
    parameter int NB_CH  = 4,
    parameter int DATA_W = 8,
    parameter int CH_W   = 2
) (
    input  logic [NB_CH*DATA_W-1:0] data_i,
    input  logic [CH_W-1:0]         sel_i,
    output logic [DATA_W-1:0]       data_o
);

    // Pick the slice whose index matches the select
    always_comb begin
        data_o = '0;
        for (int c = 0; c < NB_CH; c++) begin
            if (sel_i == CH_W'(c)) begin
                data_o = data_i[c*DATA_W +: DATA_W];
            end
        end
    end

endmodule

// File: rtl/hyperbus_chan_mux.sv
// N-channel HyperBus PHY multiplexer with a safe-switch handshake:
// a new selection is applied only after the downstream transfer drains
// and a guard interval (output parked at IDLE_VAL) has elapsed.
// Optional macro HYPERBUS_MUX_OUTREG_EN registers data_o (1-cycle latency).
module hyperbus_chan_mux
    import hyperbus_mux_pkg::*;
#(
    parameter int                NB_CH     = 4,
    parameter int                DATA_W    = 8,
    parameter int                GUARD_CYC = 2,
    parameter logic [DATA_W-1:0] IDLE_VAL  = HYPER_MUX_IDLE_DEFAULT[DATA_W-1:0],
    localparam int               CH_W      = hyper_mux_sel_w(NB_CH)
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [NB_CH*DATA_W-1:0] data_i,
    input  logic                    busy_i,
    input  logic                    sel_req_i,
    input  logic [CH_W-1:0]         sel_i,
    output logic                    sel_ack_o,
    output logic                    sel_err_o,
    output logic [CH_W-1:0]         cur_sel_o,
    output logic                    switching_o,
    output logic [DATA_W-1:0]       data_o
);

    localparam int             CNT_W    = hyper_mux_sel_w(GUARD_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(GUARD_CYC);

    hyper_mux_state_e  state_q, state_d;
    logic [CH_W-1:0]   cur_sel_q, cur_sel_d;
    logic [CH_W-1:0]   pend_sel_q, pend_sel_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              err_q, err_d;
    logic [DATA_W-1:0] mux_data;

    // Control state register; reset aborts any switch in progress
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= ACTIVE;
            cur_sel_q  <= '0;
            pend_sel_q <= '0;
            cnt_q      <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cur_sel_q  <= cur_sel_d;
            pend_sel_q <= pend_sel_d;
            cnt_q      <= cnt_d;
            err_q      <= err_d;
        end
    end

    // Next-state logic for the drain / guard / switch handshake
    always_comb begin
        state_d    = state_q;
        cur_sel_d  = cur_sel_q;
        pend_sel_d = pend_sel_q;
        cnt_d      = cnt_q;
        err_d      = err_q;
        unique case (state_q)
            ACTIVE: begin
                err_d = 1'b0;
                if (sel_req_i) begin
                    if (int'({1'b0, sel_i}) >= NB_CH) begin
                        // Invalid channel: complete at once, keep current select
                        err_d      = 1'b1;
                        pend_sel_d = cur_sel_q;
                        state_d    = SWITCH;
                    end else if (sel_i == cur_sel_q) begin
                        pend_sel_d = cur_sel_q;
                        state_d    = SWITCH;
                    end else begin
                        pend_sel_d = sel_i;
                        state_d    = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (!busy_i) begin
                    if (GUARD_CYC == 0) begin
                        state_d   = SWITCH;
                        cur_sel_d = pend_sel_q;
                    end else begin
                        state_d = GUARD;
                        cnt_d   = CNT_INIT;
                    end
                end
            end
            GUARD: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d   = SWITCH;
                    cur_sel_d = pend_sel_q;
                end
            end
            SWITCH: begin
                state_d = ACTIVE;
            end
            default: state_d = ACTIVE;
        endcase
    end

    assign sel_ack_o   = (state_q == SWITCH);
    assign sel_err_o   = (state_q == SWITCH) && err_q;
    assign switching_o = (state_q == DRAIN) || (state_q == GUARD);
    assign cur_sel_o   = cur_sel_q;

    hyperbus_chan_mux_sel #(
        .NB_CH  (NB_CH),
        .DATA_W (DATA_W),
        .CH_W   (CH_W)
    ) u_sel (
        .data_i (data_i),
        .sel_i  (cur_sel_q),
        .data_o (mux_data)
    );

`ifdef HYPERBUS_MUX_OUTREG_EN
    logic [DATA_W-1:0] data_q;

    // Registered output: park and new channel show one cycle after the state
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            data_q <= IDLE_VAL;
        end else begin
            data_q <= (state_q == GUARD) ? IDLE_VAL : mux_data;
        end
    end

    assign data_o = data_q;
`else
    // Reset is folded in so the output parks immediately on an async reset
    assign data_o = (rst_i || state_q == GUARD) ? IDLE_VAL : mux_data;
`endif

endmodule

// File: tb/tb_hyperbus_chan_mux.sv
// Directed bench for hyperbus_chan_mux (combinational-output build).
// Instance A: NB_CH=4, GUARD_CYC=2, IDLE_VAL=8'h5A.
// Instance B: NB_CH=3, GUARD_CYC=0, IDLE_VAL default (0).
module tb_hyperbus_chan_mux;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Instance A signals
    logic [31:0] data_a = {8'hD3, 8'hC2, 8'hB1, 8'hA0};
    logic        busy_a = 1'b0, req_a = 1'b0;
    logic [1:0]  sel_a  = 2'd0;
    logic        ack_a, err_a, sw_a;
    logic [1:0]  cur_a;
    logic [7:0]  dout_a;

    // Instance B signals
    logic [23:0] data_b = {8'h33, 8'h22, 8'h11};
    logic        busy_b = 1'b0, req_b = 1'b0;
    logic [1:0]  sel_b  = 2'd0;
    logic        ack_b, err_b, sw_b;
    logic [1:0]  cur_b;
    logic [7:0]  dout_b;

    hyperbus_chan_mux #(.NB_CH(4), .DATA_W(8), .GUARD_CYC(2), .IDLE_VAL(8'h5A)) dut_a (
        .clk_i(clk), .rst_i(rst), .data_i(data_a), .busy_i(busy_a),
        .sel_req_i(req_a), .sel_i(sel_a), .sel_ack_o(ack_a), .sel_err_o(err_a),
        .cur_sel_o(cur_a), .switching_o(sw_a), .data_o(dout_a)
    );

    hyperbus_chan_mux #(.NB_CH(3), .DATA_W(8), .GUARD_CYC(0)) dut_b (
        .clk_i(clk), .rst_i(rst), .data_i(data_b), .busy_i(busy_b),
        .sel_req_i(req_b), .sel_i(sel_b), .sel_ack_o(ack_b), .sel_err_o(err_b),
        .cur_sel_o(cur_b), .switching_o(sw_b), .data_o(dout_b)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic exp_a(input string t, input logic sw, input logic ack,
                         input logic [1:0] sel, input logic [7:0] d);
        chk({t, ".sw"},   32'(sw_a),   32'(sw));
        chk({t, ".ack"},  32'(ack_a),  32'(ack));
        chk({t, ".err"},  32'(err_a),  32'(0));
        chk({t, ".sel"},  32'(cur_a),  32'(sel));
        chk({t, ".data"}, 32'(dout_a), 32'(d));
    endtask

    task automatic exp_b(input string t, input logic sw, input logic ack, input logic err,
                         input logic [1:0] sel, input logic [7:0] d);
        chk({t, ".sw"},   32'(sw_b),   32'(sw));
        chk({t, ".ack"},  32'(ack_b),  32'(ack));
        chk({t, ".err"},  32'(err_b),  32'(err));
        chk({t, ".sel"},  32'(cur_b),  32'(sel));
        chk({t, ".data"}, 32'(dout_b), 32'(d));
    endtask

    // Advance to 2 time units after the next rising edge
    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset held from time 0: outputs parked
        #3;
        exp_a("rst_hold", 1'b0, 1'b0, 2'd0, 8'h5A);
        repeat (2) cyc();
        rst = 1'b0;
        cyc();
        #1 exp_a("post_rst", 1'b0, 1'b0, 2'd0, 8'hA0);
        exp_b("post_rst_b", 1'b0, 1'b0, 1'b0, 2'd0, 8'h11);

        // A: switch 0 -> 2, busy low
        cyc(); req_a = 1'b1; sel_a = 2'd2;
        #1 exp_a("sw2_c0", 1'b0, 1'b0, 2'd0, 8'hA0);
        cyc(); #1 exp_a("sw2_c1", 1'b1, 1'b0, 2'd0, 8'hA0);
        cyc(); #1 exp_a("sw2_c2", 1'b1, 1'b0, 2'd0, 8'h5A);
        cyc(); #1 exp_a("sw2_c3", 1'b1, 1'b0, 2'd0, 8'h5A);
        cyc(); #1 exp_a("sw2_c4", 1'b0, 1'b1, 2'd2, 8'hC2);
        cyc(); req_a = 1'b0;
        #1 exp_a("sw2_c5", 1'b0, 1'b0, 2'd2, 8'hC2);

        // A: switch 2 -> 1 with busy high for the first 5 DRAIN cycles
        cyc(); req_a = 1'b1; sel_a = 2'd1; busy_a = 1'b1;
        #1 exp_a("busy_c0", 1'b0, 1'b0, 2'd2, 8'hC2);
        for (int k = 1; k <= 8; k++) begin
            cyc();
            if (k == 6) busy_a = 1'b0;
            #1 exp_a($sformatf("busy_c%0d", k), 1'b1, 1'b0, 2'd2, (k <= 6) ? 8'hC2 : 8'h5A);
        end
        cyc(); #1 exp_a("busy_c9", 1'b0, 1'b1, 2'd1, 8'hB1);
        cyc(); req_a = 1'b0;
        #1 exp_a("busy_c10", 1'b0, 1'b0, 2'd1, 8'hB1);

        // A: reset asserted mid-cycle while in GUARD
        cyc(); req_a = 1'b1; sel_a = 2'd3;
        cyc();
        cyc(); #1 exp_a("grst_guard", 1'b1, 1'b0, 2'd1, 8'h5A);
        #1 rst = 1'b1; req_a = 1'b0;
        #1 exp_a("grst_async", 1'b0, 1'b0, 2'd0, 8'h5A);
        cyc(); rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            cyc(); #1 exp_a($sformatf("grst_idle%0d", k), 1'b0, 1'b0, 2'd0, 8'hA0);
        end

        // A: subsequent request completes normally
        cyc(); req_a = 1'b1; sel_a = 2'd3;
        #1 exp_a("re_c0", 1'b0, 1'b0, 2'd0, 8'hA0);
        cyc(); #1 exp_a("re_c1", 1'b1, 1'b0, 2'd0, 8'hA0);
        cyc(); #1 exp_a("re_c2", 1'b1, 1'b0, 2'd0, 8'h5A);
        cyc(); #1 exp_a("re_c3", 1'b1, 1'b0, 2'd0, 8'h5A);
        cyc(); #1 exp_a("re_c4", 1'b0, 1'b1, 2'd3, 8'hD3);
        cyc(); req_a = 1'b0;

        // A: same-channel request acks next cycle, no park
        cyc(); req_a = 1'b1; sel_a = 2'd3;
        cyc(); #1 exp_a("same_c1", 1'b0, 1'b1, 2'd3, 8'hD3);
        cyc(); req_a = 1'b0;
        #1 exp_a("same_c2", 1'b0, 1'b0, 2'd3, 8'hD3);

        // B: out-of-range request -> ack+err next cycle, select unchanged
        cyc(); req_b = 1'b1; sel_b = 2'd3;
        #1 exp_b("err_c0", 1'b0, 1'b0, 1'b0, 2'd0, 8'h11);
        cyc(); #1 exp_b("err_c1", 1'b0, 1'b1, 1'b1, 2'd0, 8'h11);
        cyc(); req_b = 1'b0;
        #1 exp_b("err_c2", 1'b0, 1'b0, 1'b0, 2'd0, 8'h11);

        // B: GUARD_CYC=0 switch 0 -> 2, ack at cycle 2, never parked
        cyc(); req_b = 1'b1; sel_b = 2'd2;
        #1 exp_b("g0_c0", 1'b0, 1'b0, 1'b0, 2'd0, 8'h11);
        cyc(); #1 exp_b("g0_c1", 1'b1, 1'b0, 1'b0, 2'd0, 8'h11);
        cyc(); #1 exp_b("g0_c2", 1'b0, 1'b1, 1'b0, 2'd2, 8'h33);
        cyc(); req_b = 1'b0;
        #1 exp_b("g0_c3", 1'b0, 1'b0, 1'b0, 2'd2, 8'h33);

        // B: same-channel request
        cyc(); req_b = 1'b1; sel_b = 2'd2;
        cyc(); #1 exp_b("bsame_c1", 1'b0, 1'b1, 1'b0, 2'd2, 8'h33);
        cyc(); req_b = 1'b0;
        #1 exp_b("bsame_c2", 1'b0, 1'b0, 1'b0, 2'd2, 8'h33);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/hyperbus_chan_mux.md
# hyperbus_chan_mux

Parametrised N-channel, W-bit channel multiplexer for the HyperBus PHY path with a safe-switch handshake. A select change is applied only after the downstream transfer drains and a programmable guard interval has elapsed. During the guard interval the output is parked at an idle value, so a switch never glitches a live transaction. The block sits between the per-channel uDMA/controller outputs and the shared HyperBus pad logic.

## Interface
- NB_CH, 4: number of input channels, ≥2
- DATA_W, 8: bits per channel
- GUARD_CYC, 2: idle-parked cycles between drain and switch, ≥0
- IDLE_VAL, '0: DATA_W-bit value driven during the guard interval and after reset
- CH_W, $clog2(NB_CH): localparam, select width
- clk_i  in  1  clock
- rst_i  in  1  reset; asynchronous, active-high
- data_i  in  NB_CH*DATA_W  channel c occupies bits [c*DATA_W +: DATA_W]
- busy_i  in  1  downstream transfer in flight; blocks a switch
- sel_req_i  in  1  switch request; level, held until sel_ack_o
- sel_i  in  CH_W  requested channel; stable while sel_req_i is high
- sel_ack_o  out  1  one-cycle request completion
- sel_err_o  out  1  one-cycle flag, coincident with ack, when sel_i ≥ NB_CH
- cur_sel_o  out  CH_W  active channel
- switching_o  out  1  high in DRAIN and GUARD
- data_o  out  DATA_W  selected channel data

## Operation
- FSM states: ACTIVE, DRAIN, GUARD, SWITCH.
- ACTIVE, sel_req_i=1:
  - sel_i ≥ NB_CH: go to SWITCH with error flagged; cur_sel unchanged.
  - sel_i == cur_sel: go to SWITCH; no change.
  - Otherwise: latch sel_i into pend_sel and go to DRAIN.
- DRAIN:
  - data_o follows the old channel.
  - Exit when busy_i is sampled low: to GUARD (cnt ← GUARD_CYC), or straight to SWITCH if GUARD_CYC=0.
- GUARD:
  - data_o = IDLE_VAL; cnt decrements each cycle.
  - At cnt==1, go to SWITCH. busy_i is ignored in this state.
- SWITCH:
  - cur_sel ← pend_sel, applied on the edge entering SWITCH.
  - sel_ack_o=1 (sel_err_o=1 when flagged).
  - Go to ACTIVE. sel_req_i is ignored in this state.
- sel_req_i is ignored outside ACTIVE. A requester must drop sel_req_i the cycle after ack, otherwise a new request is taken.
- Reset values: state ACTIVE, cur_sel 0, cnt 0, data_o IDLE_VAL, sel_ack_o/sel_err_o/switching_o 0.
- Reset mid-switch aborts to the reset state; the pending selection is lost and no ack is given.

## Timing
- Valid switch with req sampled at edge 1 and busy_i low: DRAIN after edge 1, GUARD after edge 2, SWITCH after edge 2+GUARD_CYC.
  - Ack occurs GUARD_CYC+2 cycles after the first req cycle.
  - Each extra busy_i-high cycle in DRAIN adds one cycle.
- Same-channel or error request: ack in the cycle after the first req cycle.
- data_o latency from data_i: see Configuration.
- IDLE_VAL is present on data_o for exactly GUARD_CYC cycles, or 0 cycles when GUARD_CYC=0.

## Configuration
- HYPERBUS_MUX_OUTREG_EN defined:
  - data_o is a flop, 1-cycle latency from data_i/cur_sel.
  - The guard park and the new channel appear one cycle later than the state.
  - Reset value is IDLE_VAL.
- Undefined: data_o is combinational. It shows data_i[cur_sel], or IDLE_VAL while in GUARD.
- FSM and handshake timing are identical in both builds.

## Structure
- hyperbus_mux_pkg:
  - state enum hyper_mux_state_e;
  - a function for the select width;
  - default IDLE_VAL constant.
- Sub-module hyperbus_chan_mux_sel: purely combinational NB_CH:1 array mux (data_i, sel → data), instantiated once.

## Test plan
- Reset: assert rst_i mid-cycle → data_o=IDLE_VAL, cur_sel_o=0, sel_ack_o=0 immediately (async).
- NB_CH=4, GUARD_CYC=2, busy_i=0, req sel_i=2 at cycle 0:
  - switching_o high cycles 1–3;
  - data_o=IDLE_VAL for 2 cycles;
  - ack in cycle 4 with cur_sel_o=2;
  - data_o=data_i channel 2 afterwards.
- Same request with busy_i high for 5 cycles → ack delayed by exactly 5 cycles; old channel data visible throughout DRAIN.
- NB_CH=3, req sel_i=3 → sel_ack_o and sel_err_o pulse together next cycle; cur_sel_o unchanged; no IDLE_VAL park.
- GUARD_CYC=0, req for a different channel → ack at cycle 2; data_o never shows IDLE_VAL.
- Reset asserted in GUARD → FSM returns to ACTIVE/channel 0 with no ack. A subsequent request then completes normally.
